// File: rtl/bcd_to_bin_accum_if.sv
// Digit-in / result-out bus for bcd_to_bin_accum.
// slave: the accumulator side. master: the producer/consumer side.
interface bcd_to_bin_accum_if #(
    parameter int NDIG = 4,
    parameter int OW   = 14
);
    localparam int CW = $clog2(NDIG + 1);

    logic [3:0]    IN;
    logic          IN_VALID;
    logic          IN_LAST;
    logic          IN_READY;
    logic [OW-1:0] OT;
    logic          OT_VALID;
    logic          OT_READY;
    logic [CW-1:0] ODIGS;
    logic          ERR;

    modport slave (
        input  IN, IN_VALID, IN_LAST, OT_READY,
        output IN_READY, OT, OT_VALID, ODIGS, ERR
    );

    modport master (
        output IN, IN_VALID, IN_LAST, OT_READY,
        input  IN_READY, OT, OT_VALID, ODIGS, ERR
    );
endinterface

// File: rtl/bcd_to_bin_accum.sv
// bcd_to_bin_accum: folds a most-significant-first stream of decimal digits
// into an unsigned binary value (acc = acc*10 + d, wrapping mod 2^OW) and
// presents it with its digit count and an invalid-digit flag.
//
// Optional build macro BCDACC_EX3_IN_EN: IN carries excess-3 codes that are
// decoded here (d = IN-3, codes 0..2 and 13..15 invalid). Without it IN is
// plain BCD and codes 10..15 are invalid.
//
// state | meaning
// ACC   | accepting digits, IN_READY high
// OUT   | result held on OT until the consumer takes it
module bcd_to_bin_accum #(
    parameter int NDIG = 4,
    parameter int OW   = 14
) (
    input  logic                 CLK,
    input  logic                 RST,
    bcd_to_bin_accum_if.slave    bus
);
    localparam int CW = $clog2(NDIG + 1);

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [OW-1:0] acc;
    logic [OW-1:0] acc_x10;
    logic [OW-1:0] acc_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          errf;

    logic [3:0]    dig;
    logic          dig_bad;
    logic          in_ready;
    logic          accept;
    logic          close;
    logic          handoff;

    logic [OW-1:0] ot_q;
    logic          ot_valid_q;
    logic [CW-1:0] odigs_q;
    logic          err_q;

    // IN_READY comes straight from the state register, held low during reset.
    assign in_ready = (state == S_ACC) && !RST;

    assign accept   = bus.IN_VALID && in_ready;
    assign handoff  = ot_valid_q && bus.OT_READY;

    // Digit decode: invalid codes contribute zero and raise the error flag.
    always_comb begin
        dig_bad = 1'b0;
        dig     = 4'd0;
`ifdef BCDACC_EX3_IN_EN
        dig_bad = (bus.IN < 4'd3) || (bus.IN > 4'd12);
        dig     = dig_bad ? 4'd0 : (bus.IN - 4'd3);
`else
        dig_bad = (bus.IN > 4'd9);
        dig     = dig_bad ? 4'd0 : bus.IN;
`endif
    end

    // Multiply-by-ten as shift-add; overflow wraps silently at OW bits.
    always_comb begin
        acc_x10 = (acc << 3) + (acc << 1);
        acc_nxt = acc_x10 + OW'(dig);
        cnt_inc = cnt + CW'(1);
        close   = bus.IN_LAST || (cnt_inc == CW'(NDIG));
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_ACC: begin
                if (accept && close) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (handoff) begin
                    state_nxt = S_ACC;
                end
            end
            default: state_nxt = S_ACC;
        endcase
    end

    // Accumulator and result registers. OT/ODIGS/ERR are only loaded when a
    // number closes, so they keep their value after the result is taken.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc        <= '0;
            cnt        <= '0;
            errf       <= 1'b0;
            ot_q       <= '0;
            ot_valid_q <= 1'b0;
            odigs_q    <= '0;
            err_q      <= 1'b0;
        end else if (accept) begin
            acc  <= acc_nxt;
            cnt  <= cnt_inc;
            errf <= errf | dig_bad;
            if (close) begin
                ot_q       <= acc_nxt;
                odigs_q    <= cnt_inc;
                err_q      <= errf | dig_bad;
                ot_valid_q <= 1'b1;
            end
        end else if (handoff) begin
            ot_valid_q <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            errf       <= 1'b0;
        end
    end

    assign bus.IN_READY = in_ready;
    assign bus.OT       = ot_q;
    assign bus.OT_VALID = ot_valid_q;
    assign bus.ODIGS    = odigs_q;
    assign bus.ERR      = err_q;

endmodule

// File: tb/tb_bcd_to_bin_accum.sv
// Bench for bcd_to_bin_accum: directed digit sequences with literal result
// expectations, then randomized traffic checked every cycle against a
// digit-queue model of the accumulator.
module tb_bcd_to_bin_accum;
    localparam int NDIG = 4;
    localparam int OW   = 14;

`ifdef BCDACC_EX3_IN_EN
    localparam int BAD_CODE = 1;
`else
    localparam int BAD_CODE = 11;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;

    bcd_to_bin_accum_if #(.NDIG(NDIG), .OW(OW)) bus ();

    bcd_to_bin_accum #(.NDIG(NDIG), .OW(OW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit is_bad(input int code);
`ifdef BCDACC_EX3_IN_EN
        return (code < 3) || (code > 12);
`else
        return code > 9;
`endif
    endfunction

    function automatic int dval(input int code);
        if (is_bad(code)) return 0;
`ifdef BCDACC_EX3_IN_EN
        return code - 3;
`else
        return code;
`endif
    endfunction

    function automatic int enc(input int d);
`ifdef BCDACC_EX3_IN_EN
        return d + 3;
`else
        return d;
`endif
    endfunction

    // Behavioural model: digits of the open number kept as a list; the value
    // is formed as a decimal number only when the number closes.
    bit m_out    = 1'b0;
    bit m_ovalid = 1'b0;
    int m_ot     = 0;
    int m_odigs  = 0;
    bit m_err    = 1'b0;
    bit m_errf   = 1'b0;
    int q[$];
    bit mon_en   = 1'b0;
    int n_results = 0;

    always @(negedge CLK) begin
        if (mon_en) begin
            chk("in_ready", 32'(bus.IN_READY), 32'(!RST && !m_out));
            chk("ot_valid", 32'(bus.OT_VALID), 32'(m_ovalid));
            chk("ot",       32'(bus.OT),       32'(m_ot));
            chk("odigs",    32'(bus.ODIGS),    32'(m_odigs));
            chk("err",      32'(bus.ERR),      32'(m_err));
            if (RST) begin
                m_out = 0; m_ovalid = 0; m_ot = 0; m_odigs = 0; m_err = 0;
                m_errf = 0; q.delete();
            end else if (!m_out) begin
                if (bus.IN_VALID) begin
                    q.push_back(dval(int'(bus.IN)));
                    m_errf = m_errf | is_bad(int'(bus.IN));
                    if (bus.IN_LAST || q.size() == NDIG) begin
                        int v;
                        v = 0;
                        foreach (q[i]) v = (v * 10 + q[i]) % (1 << OW);
                        m_ot = v; m_odigs = q.size(); m_err = m_errf;
                        m_ovalid = 1; m_out = 1;
                    end
                end
            end else if (bus.OT_READY) begin
                m_ovalid = 0; m_out = 0; m_errf = 0; q.delete();
                n_results++;
            end
        end
    end

    // Present one digit and hold it until accepted; returns just after the
    // accepting edge with IN_VALID dropped.
    task automatic send(input int code, input bit last);
        bus.IN = 4'(code); bus.IN_VALID = 1'b1; bus.IN_LAST = last;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (bus.IN_READY === 1'b1) begin
                @(posedge CLK); #1;
                bus.IN_VALID = 1'b0; bus.IN_LAST = 1'b0;
                return;
            end
        end
        chk("send_timeout", 32'(bus.IN_READY), 32'd1);
        bus.IN_VALID = 1'b0; bus.IN_LAST = 1'b0;
    endtask

    // Wait (bounded) for a result and pin both DUT and model to literals.
    task automatic expect_result(input string tag, input int ot, input int digs, input bit err);
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (bus.OT_VALID === 1'b1) begin
                chk({tag, "_ot"},     32'(bus.OT),    32'(ot));
                chk({tag, "_odigs"},  32'(bus.ODIGS), 32'(digs));
                chk({tag, "_err"},    32'(bus.ERR),   32'(err));
                chk({tag, "_model"},  32'(m_ot),      32'(ot));
                @(posedge CLK); #1;
                return;
            end
        end
        chk({tag, "_timeout"}, 32'(bus.OT_VALID), 32'd1);
    endtask

    initial begin
        bus.IN = 4'd0; bus.IN_VALID = 1'b0; bus.IN_LAST = 1'b0; bus.OT_READY = 1'b1;
        RST = 1'b1;
        @(posedge CLK); #1;
        mon_en = 1'b1;
        @(negedge CLK);
        chk("rst_in_ready", 32'(bus.IN_READY), 32'd0);
        chk("rst_ot_valid", 32'(bus.OT_VALID), 32'd0);
        chk("rst_ot",       32'(bus.OT),       32'd0);
        chk("rst_odigs",    32'(bus.ODIGS),    32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // 1,2,3,4 without IN_LAST: closes on the 4th digit, one-cycle result.
        send(enc(1), 0); send(enc(2), 0); send(enc(3), 0); send(enc(4), 0);
        @(negedge CLK);
        chk("t1_ot_valid", 32'(bus.OT_VALID), 32'd1);
        chk("t1_ot",       32'(bus.OT),       32'd1234);
        chk("t1_odigs",    32'(bus.ODIGS),    32'd4);
        chk("t1_err",      32'(bus.ERR),      32'd0);
        @(negedge CLK);
        chk("t1_pulse",    32'(bus.OT_VALID), 32'd0);
        chk("t1_ready",    32'(bus.IN_READY), 32'd1);
        chk("t1_hold_ot",  32'(bus.OT),       32'd1234);
        @(posedge CLK); #1;

        send(enc(0), 0); send(enc(7), 1);
        expect_result("t2a", 7, 2, 0);
        send(enc(9), 0); send(enc(9), 0); send(enc(9), 0); send(enc(9), 0);
        expect_result("t2b", 9999, 4, 0);

        send(enc(5), 0); send(BAD_CODE, 0); send(enc(2), 1);
        expect_result("t3a", 502, 3, 1);
        send(enc(3), 1);
        expect_result("t3b", 3, 1, 0);

        // Backpressure: result held, extra digits refused.
        bus.OT_READY = 1'b0;
        send(enc(6), 1);
        bus.IN = 4'(enc(3)); bus.IN_VALID = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("bp_ot_valid", 32'(bus.OT_VALID), 32'd1);
            chk("bp_ot",       32'(bus.OT),       32'd6);
            chk("bp_in_ready", 32'(bus.IN_READY), 32'd0);
        end
        @(posedge CLK); #1;
        bus.OT_READY = 1'b1; bus.IN_VALID = 1'b0;
        @(negedge CLK);
        chk("bp_still_busy", 32'(bus.IN_READY), 32'd0);
        @(negedge CLK);
        chk("bp_released",   32'(bus.IN_READY), 32'd1);
        chk("bp_ot_drop",    32'(bus.OT_VALID), 32'd0);
        @(posedge CLK); #1;

        // Reset mid-number discards the partial value.
        send(enc(4), 0); send(enc(2), 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_ready", 32'(bus.IN_READY), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        send(enc(8), 1);
        expect_result("t5", 8, 1, 0);

`ifdef BCDACC_EX3_IN_EN
        send(4, 0); send(5, 0); send(6, 1);
        expect_result("ex3a", 123, 3, 0);
        send(1, 1);
        expect_result("ex3b", 0, 1, 1);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK); #1;
            RST          = ($urandom_range(0, 299) == 0);
            bus.IN_VALID = ($urandom_range(0, 3) != 0);
            bus.IN       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'(enc($urandom_range(0, 9)));
            bus.IN_LAST  = ($urandom_range(0, 3) == 0);
            bus.OT_READY = ($urandom_range(0, 2) != 0);
        end
        @(posedge CLK); #1;
        RST = 1'b0; bus.IN_VALID = 1'b0; bus.IN_LAST = 1'b0; bus.OT_READY = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        chk("random_progress", 32'(n_results > 100), 32'd1);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
